// File: rtl/noc_router_adapter_fifo.sv
// AXI-Stream to NoC router adapter: buffers ingress beats in a synchronous FIFO,
// stamps the source address into tid and splits packets longer than MAX_BEATS.
module noc_router_adapter_fifo #(
    parameter int NOC_DW     = 32,
    parameter int BYTE_DW    = 8,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BEATS  = 64,
    parameter int STAMP_SRC  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             router_address,
    input  logic                          slave_tvalid,
    output logic                          slave_tready,
    input  logic [NOC_DW-1:0]             slave_tdata,
    input  logic [NOC_DW/BYTE_DW-1:0]     slave_tstrb,
    input  logic [NOC_DW/BYTE_DW-1:0]     slave_tkeep,
    input  logic [BYTE_DW-1:0]            slave_tid,
    input  logic [BYTE_DW-1:0]            slave_tdest,
    input  logic [BYTE_DW-1:0]            slave_tuser,
    input  logic                          slave_tlast,
    output logic                          master_tvalid,
    input  logic                          master_tready,
    output logic [NOC_DW-1:0]             master_tdata,
    output logic [NOC_DW/BYTE_DW-1:0]     master_tstrb,
    output logic [NOC_DW/BYTE_DW-1:0]     master_tkeep,
    output logic [BYTE_DW-1:0]            master_tid,
    output logic [BYTE_DW-1:0]            master_tdest,
    output logic [BYTE_DW-1:0]            master_tuser,
    output logic                          master_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   pkt_count
);

    localparam int SW  = NOC_DW / BYTE_DW;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int BCW = $clog2(MAX_BEATS + 1);
    localparam int EW  = NOC_DW + 2 * SW + 3 * BYTE_DW + 1;

    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [15:0]        pkt_cnt_q, pkt_cnt_d;

    logic               wr_en_s;
    logic               rd_en_s;
    logic               split_last_s;
    logic [BYTE_DW-1:0] tid_s;
    logic [EW-1:0]      wr_entry_s;
    logic [EW-1:0]      head_s;

    // Ready comes from the registered level only, so a pop never frees a slot in the same cycle.
    assign slave_tready  = (level_q != LW'(FIFO_DEPTH)) && !reset;
    assign master_tvalid = (level_q != LW'(0));
    assign wr_en_s       = slave_tvalid && slave_tready;
    assign rd_en_s       = master_tvalid && master_tready;

    // Build the stored beat: stamped tid and packet-length limited tlast.
    always_comb begin
        tid_s        = slave_tid;
        split_last_s = slave_tlast || (beat_cnt_q == BCW'(MAX_BEATS - 1));
        if (STAMP_SRC != 0) begin
            tid_s = BYTE_DW'(router_address);
        end else begin
            tid_s = slave_tid;
        end
        wr_entry_s = {slave_tdata, slave_tstrb, slave_tkeep, tid_s,
                      slave_tdest, slave_tuser, split_last_s};
    end

    // Head entry, zeroed while empty so stale storage never reaches the router.
    always_comb begin
        head_s = '0;
        if (master_tvalid) begin
            head_s = mem_q[rd_ptr_q];
        end else begin
            head_s = '0;
        end
    end

    assign {master_tdata, master_tstrb, master_tkeep, master_tid,
            master_tdest, master_tuser, master_tlast} = head_s;
    assign fifo_level = level_q;
    assign pkt_count  = pkt_cnt_q;

    // Next-state for pointers, occupancy, beat counter and packet counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (split_last_s) begin
                beat_cnt_d = BCW'(0);
            end else begin
                beat_cnt_d = beat_cnt_q + BCW'(1);
            end
        end else begin
            wr_ptr_d   = wr_ptr_q;
            beat_cnt_d = beat_cnt_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (head_s[0]) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // Storage array; contents are don't-care until written since the head is masked when empty.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

endmodule

// File: tb/tb_noc_router_adapter_fifo.sv
// Directed and randomised checks of noc_router_adapter_fifo against a queue-based model.
module tb_noc_router_adapter_fifo;

    localparam int DEPTH = 16;
    localparam int MAXB  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  router_address;
    logic        slave_tvalid, slave_tready, slave_tready_ns;
    logic [31:0] slave_tdata;
    logic [3:0]  slave_tstrb, slave_tkeep;
    logic [7:0]  slave_tid, slave_tdest, slave_tuser;
    logic        slave_tlast;
    logic        master_tvalid, master_tready;
    logic [31:0] master_tdata;
    logic [3:0]  master_tstrb, master_tkeep;
    logic [7:0]  master_tid, master_tdest, master_tuser;
    logic        master_tlast;
    logic [4:0]  fifo_level;
    logic [15:0] pkt_count;
    logic        mvalid_ns, mlast_ns;
    logic [31:0] mdata_ns;
    logic [3:0]  mstrb_ns, mkeep_ns;
    logic [7:0]  mtid_ns, mtdest_ns, mtuser_ns;
    logic [4:0]  level_ns;
    logic [15:0] pkt_ns;

    always #5 clk = ~clk;

    noc_router_adapter_fifo #(.NOC_DW(32), .BYTE_DW(8), .ADDR_W(4), .FIFO_DEPTH(DEPTH),
                              .MAX_BEATS(MAXB), .STAMP_SRC(1)) dut (
        .clk(clk), .reset(reset), .router_address(router_address),
        .slave_tvalid(slave_tvalid), .slave_tready(slave_tready), .slave_tdata(slave_tdata),
        .slave_tstrb(slave_tstrb), .slave_tkeep(slave_tkeep), .slave_tid(slave_tid),
        .slave_tdest(slave_tdest), .slave_tuser(slave_tuser), .slave_tlast(slave_tlast),
        .master_tvalid(master_tvalid), .master_tready(master_tready), .master_tdata(master_tdata),
        .master_tstrb(master_tstrb), .master_tkeep(master_tkeep), .master_tid(master_tid),
        .master_tdest(master_tdest), .master_tuser(master_tuser), .master_tlast(master_tlast),
        .fifo_level(fifo_level), .pkt_count(pkt_count));

    noc_router_adapter_fifo #(.NOC_DW(32), .BYTE_DW(8), .ADDR_W(4), .FIFO_DEPTH(DEPTH),
                              .MAX_BEATS(64), .STAMP_SRC(0)) dut_ns (
        .clk(clk), .reset(reset), .router_address(router_address),
        .slave_tvalid(slave_tvalid), .slave_tready(slave_tready_ns), .slave_tdata(slave_tdata),
        .slave_tstrb(slave_tstrb), .slave_tkeep(slave_tkeep), .slave_tid(slave_tid),
        .slave_tdest(slave_tdest), .slave_tuser(slave_tuser), .slave_tlast(slave_tlast),
        .master_tvalid(mvalid_ns), .master_tready(master_tready), .master_tdata(mdata_ns),
        .master_tstrb(mstrb_ns), .master_tkeep(mkeep_ns), .master_tid(mtid_ns),
        .master_tdest(mtdest_ns), .master_tuser(mtuser_ns), .master_tlast(mlast_ns),
        .fifo_level(level_ns), .pkt_count(pkt_ns));

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [7:0]  user;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  ns_q[$];
    int          model_beat = 0;
    logic [15:0] model_pkt  = 16'd0;
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_wr       = 0;
    int          out_idx    = 0;
    int          n_out_last = 0;
    logic [15:0] last_mask  = 16'd0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input logic v, input logic [31:0] d, input logic l);
        slave_tvalid = v;
        slave_tdata  = d;
        slave_tstrb  = d[3:0];
        slave_tkeep  = d[7:4];
        slave_tid    = d[15:8];
        slave_tdest  = d[23:16];
        slave_tuser  = d[31:24];
        slave_tlast  = l;
    endtask

    // Called at a falling edge with inputs set: checks, updates the model, advances one cycle.
    task automatic step();
        beat_t e;
        beat_t h;
        logic  wr, rd, wr_ns, rd_ns;
        logic [7:0] t;
        #1;
        check_eq("fifo_level", 64'(fifo_level), 64'(exp_q.size()));
        check_eq("master_tvalid", 64'(master_tvalid), 64'(exp_q.size() != 0));
        check_eq("slave_tready", 64'(slave_tready), 64'((exp_q.size() != DEPTH) && !reset));
        check_eq("pkt_count", 64'(pkt_count), 64'(model_pkt));
        if (exp_q.size() == 0) begin
            check_eq("empty_data", 64'(master_tdata), 64'd0);
            check_eq("empty_side", 64'({master_tstrb, master_tkeep, master_tid,
                                        master_tdest, master_tuser, master_tlast}), 64'd0);
        end
        wr    = slave_tvalid && slave_tready;
        rd    = master_tvalid && master_tready;
        wr_ns = slave_tvalid && slave_tready_ns;
        rd_ns = mvalid_ns && master_tready;
        if (reset) begin
            exp_q.delete();
            ns_q.delete();
            model_beat = 0;
            model_pkt  = 16'd0;
            n_out_last = 0;
        end else begin
            if (rd && exp_q.size() > 0) begin
                h = exp_q.pop_front();
                check_eq("out_data", 64'(master_tdata), 64'(h.data));
                check_eq("out_side", 64'({master_tstrb, master_tkeep, master_tid, master_tdest,
                                          master_tuser, master_tlast}),
                         64'({h.strb, h.keep, h.id, h.dest, h.user, h.last}));
                if (h.last) model_pkt = model_pkt + 16'd1;
                if (master_tlast) n_out_last++;
                if (out_idx < 16) last_mask[out_idx] = master_tlast;
                out_idx++;
            end
            if (rd_ns && ns_q.size() > 0) begin
                t = ns_q.pop_front();
                check_eq("ns_tid", 64'(mtid_ns), 64'(t));
            end
            if (wr) begin
                e.data = slave_tdata;
                e.strb = slave_tstrb;
                e.keep = slave_tkeep;
                e.id   = {4'h0, router_address};
                e.dest = slave_tdest;
                e.user = slave_tuser;
                e.last = slave_tlast || (model_beat == MAXB - 1);
                model_beat = e.last ? 0 : model_beat + 1;
                exp_q.push_back(e);
                n_wr++;
            end
            if (wr_ns) ns_q.push_back(slave_tid);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int cyc;
        reset          = 1'b1;
        router_address = 4'h3;
        master_tready  = 1'b0;
        set_beat(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        step();

        // 4-beat packet, tlast on beat 3, router always ready
        master_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(1'b1, 32'h1000_0000 + 32'(i * 32'h0101_0111), i == 3);
            step();
        end
        set_beat(1'b0, 32'h0, 1'b0);
        step();
        step();
        check_eq("basic_pkt_count", 64'(pkt_count), 64'd1);
        check_eq("basic_level", 64'(fifo_level), 64'd0);

        // fill until stall, then drain
        master_tready = 1'b0;
        acc = n_wr;
        for (int i = 0; i < 20; i++) begin
            set_beat(1'b1, 32'h9E37_79B9 * 32'(i + 1), 1'b0);
            step();
        end
        check_eq("fill_accepted", 64'(n_wr - acc), 64'd16);
        check_eq("fill_level", 64'(fifo_level), 64'd16);
        check_eq("fill_ready", 64'(slave_tready), 64'd0);
        set_beat(1'b0, 32'h0, 1'b0);
        master_tready = 1'b1;
        step();
        check_eq("ready_after_pop", 64'(slave_tready), 64'd1);
        for (int i = 0; i < 16; i++) step();
        check_eq("fill_pkt_count", 64'(pkt_count), 64'd5);

        // 10-beat packet split at MAX_BEATS=4
        out_idx   = 0;
        last_mask = 16'd0;
        for (int i = 0; i < 10; i++) begin
            set_beat(1'b1, 32'hC0DE_0000 + 32'(i * 32'h0003_0405), i == 9);
            step();
        end
        set_beat(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check_eq("split_mask", 64'(last_mask[9:0]), 64'(10'b10_1000_1000));
        check_eq("split_pkt_count", 64'(pkt_count), 64'd8);

        // tid stamping versus passthrough
        router_address = 4'hA;
        master_tready  = 1'b0;
        set_beat(1'b1, 32'h7766_5500, 1'b1);
        step();
        set_beat(1'b0, 32'h0, 1'b0);
        #1;
        check_eq("stamp_tid", 64'(master_tid), 64'h0A);
        check_eq("pass_tid", 64'(mtid_ns), 64'h55);
        master_tready = 1'b1;
        step();
        step();

        // reset with 5 beats buffered mid-packet
        master_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat(1'b1, 32'h5A00_0000 + 32'(i), 1'b0);
            step();
        end
        check_eq("pre_reset_level", 64'(fifo_level), 64'd5);
        set_beat(1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("post_reset_valid", 64'(master_tvalid), 64'd0);
        check_eq("post_reset_level", 64'(fifo_level), 64'd0);
        out_idx       = 0;
        last_mask     = 16'd0;
        master_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(1'b1, 32'h6B00_1200 + 32'(i), 1'b0);
            step();
        end
        set_beat(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check_eq("reset_split_mask", 64'(last_mask[3:0]), 64'(4'b1000));
        check_eq("reset_pkt_count", 64'(pkt_count), 64'd1);

        // random traffic, 1000 beats
        acc = n_wr;
        cyc = 0;
        while ((n_wr - acc) < 1000 && cyc < 20000) begin
            set_beat(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0));
            master_tready = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        check_eq("rand_budget", 64'(cyc < 20000), 64'd1);
        set_beat(1'b0, 32'h0, 1'b0);
        master_tready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            step();
            cyc++;
        end
        step();
        check_eq("rand_drained", 64'(fifo_level), 64'd0);
        check_eq("rand_pkt_vs_tlast", 64'(pkt_count), 64'(16'(n_out_last)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/noc_router_adapter_fifo.md
# noc_router_adapter_fifo

Parametrised NoC router adapter that buffers an AXI-Stream flow from user logic (slave side) into the NoC router (master side) through a synchronous FIFO. It stamps the source router address into `tid` and enforces a maximum packet length by splitting long packets. It also exposes occupancy and packet-count status. It sits between a user core and one NoC router port and replaces the fixed-width, unbuffered adapter.

## Interface
- `NOC_DW`, 32, NoC data width in bits; multiple of `BYTE_DW`
- `BYTE_DW`, 8, byte width; also the width of `tid`/`tdest`/`tuser`
- `ADDR_W`, 4, router address width; must be ≤ `BYTE_DW`
- `FIFO_DEPTH`, 16, entries; power of two, ≥ 2
- `MAX_BEATS`, 64, maximum beats per output packet; ≥ 1
- `STAMP_SRC`, 1, 1 = replace `tid` with zero-extended `router_address`; 0 = pass `tid` through

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `router_address`  in  `ADDR_W`  this router's address; sampled on each write
- `slave_tvalid`  in  1  ingress beat valid
- `slave_tready`  out  1  ingress ready
- `slave_tdata`  in  `NOC_DW`  ingress data
- `slave_tstrb`, `slave_tkeep`  in  `NOC_DW/BYTE_DW` each  byte qualifiers
- `slave_tid`, `slave_tdest`, `slave_tuser`  in  `BYTE_DW` each  sideband
- `slave_tlast`  in  1  end of packet
- `master_tvalid`  out  1  egress beat valid
- `master_tready`  in  1  egress ready from router
- `master_tdata`, `master_tstrb`, `master_tkeep`, `master_tid`, `master_tdest`, `master_tuser`, `master_tlast`  out  same widths as slave counterparts
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  current occupancy
- `pkt_count`  out  16  packets sent (egress `tlast` handshakes), wrapping

## Operation
- Write: occurs when `slave_tvalid && slave_tready`. The full beat is stored with `tid` stamped per `STAMP_SRC` and `tlast` forced as below.
- Read: occurs when `master_tvalid && master_tready`. The head entry is popped.
- `slave_tready = (fifo_level != FIFO_DEPTH) && !reset`.
- `master_tvalid = (fifo_level != 0)`.
- Master outputs are driven from the head entry. They are held stable while `master_tvalid && !master_tready`.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_level` increments by 1 on write only, decrements by 1 on read only, and is unchanged on simultaneous write and read.
- Full with a pop in the same cycle: no write occurs, because ready is derived from the registered level.
- Packet limiter: an ingress beat counter `beat_cnt` runs from 0 to `MAX_BEATS-1`.
  - Stored `tlast = slave_tlast || (beat_cnt == MAX_BEATS-1)`.
  - On a write with stored `tlast`, `beat_cnt` clears to 0; on any other write it increments.
  - The beat after a forced split starts a new packet. `tdest`, `tuser` and `tid` are carried unchanged on every beat.
- `pkt_count` increments on each read whose entry has `tlast = 1`; it wraps from 0xFFFF to 0.

## Timing
- Reset values: `fifo_level` 0, pointers 0, `beat_cnt` 0, `pkt_count` 0, `master_tvalid` 0, `slave_tready` 0 while `reset` is high. Master data outputs are 0 while empty after reset.
- Reset mid-packet discards all FIFO contents and the partial count. The first write after reset is treated as beat 0 of a new packet.
- Latency: a beat written at edge N is visible at the master outputs in the cycle after edge N. `master_tvalid` is high from that cycle, provided the FIFO was empty.
- `slave_tready` is high in the first cycle after `reset` deasserts.
- Throughput: one beat per cycle sustained when `master_tready` is held high.
- No combinational path from `master_tready` to `slave_tready`.

## Test plan
- Reset, then 4 beats with `tlast` on beat 3 and `master_tready=1` → 4 beats out in order, first one cycle after its write; `pkt_count`=1; `fifo_level` returns to 0.
- `master_tready=0`, push until stall (`FIFO_DEPTH`=16) → exactly 16 beats accepted; `slave_tready`=0 and `fifo_level`=16. Raise `master_tready` → all 16 beats drain in order, and `slave_tready` rises the cycle after the first pop.
- `MAX_BEATS`=4, send a 10-beat packet → output `tlast` on beats 3, 7 and 9; `pkt_count`=3.
- `STAMP_SRC`=1, `router_address`=4'hA, `slave_tid`=8'h55 → `master_tid`=8'h0A. With `STAMP_SRC`=0 → `master_tid`=8'h55.
- Assert `reset` for 1 cycle with 5 beats buffered mid-packet → `master_tvalid`=0 and `fifo_level`=0 next cycle. The next packet of 4 beats (`MAX_BEATS`=4) ends with `tlast` on its own beat 3.
- Random valid/ready at 50%, 1000 beats → scoreboard matches data and sideband exactly. `fifo_level` never exceeds 16 and never underflows. `pkt_count` equals the number of output `tlast` beats.
